// File: rtl/lms_step_scheduler.sv
// lms_step_scheduler: sequences the adaptive filter step size through
// training, geometric decay and low-mu tracking, and re-enters training
// when the error stays large for too many consecutive samples.
module lms_step_scheduler #(
  parameter int WIDTH       = 16,
  parameter int FRAC        = 15,
  parameter int MU_INIT     = 3276,
  parameter int MU_MIN      = 400,
  parameter int TRAIN_LEN   = 256,
  parameter int DECAY_LEN   = 64,
  parameter int CONV_THRESH = 328,
  parameter int DIV_THRESH  = 6554,
  parameter int DIV_COUNT   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    freeze,
  input  logic                    sample_valid,
  input  logic signed [WIDTH-1:0] error,
  output logic        [WIDTH-1:0] step_size,
  output logic                    adapt_en,
  output logic        [2:0]       state,
  output logic                    converged,
  output logic                    retrain
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TRAIN = 3'd1,
    ST_DECAY = 3'd2,
    ST_TRACK = 3'd3
  } state_t;

  localparam int PH_MAX = (TRAIN_LEN > DECAY_LEN) ? TRAIN_LEN : DECAY_LEN;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int DV_W   = $clog2(DIV_COUNT + 1);

  // Largest positive Q1.FRAC value; the saturated magnitude of the most negative error
  localparam logic [WIDTH-1:0] MAG_MAX    = WIDTH'((1 << FRAC) - 1);
  localparam logic [WIDTH-1:0] MU_INIT_V  = WIDTH'(MU_INIT);
  localparam logic [WIDTH-1:0] MU_MIN_V   = WIDTH'(MU_MIN);
  localparam logic [WIDTH-1:0] CONV_THR_V = WIDTH'(CONV_THRESH);
  localparam logic [WIDTH-1:0] DIV_THR_V  = WIDTH'(DIV_THRESH);
  localparam logic [PH_W-1:0]  TRAIN_TC   = PH_W'(TRAIN_LEN);
  localparam logic [PH_W-1:0]  DECAY_TC   = PH_W'(DECAY_LEN);
  localparam logic [DV_W-1:0]  DIV_TC     = DV_W'(DIV_COUNT);

  // Saturating absolute value: the most negative code maps to MAG_MAX
  function automatic logic [WIDTH-1:0] sat_abs(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    if (x == $signed({1'b1, {(WIDTH-1){1'b0}}})) begin
      r = MAG_MAX;
    end else if (x[WIDTH-1]) begin
      r = $unsigned(-x);
    end else begin
      r = $unsigned(x);
    end
    return r;
  endfunction

  state_t           cur_state_r, nxt_state_s;
  logic [WIDTH-1:0] mu_r, mu_nxt_s, mu_half_s, mu_dec_s, mag_s;
  logic [PH_W-1:0]  ph_r, ph_nxt_s, ph_inc_s;
  logic [DV_W-1:0]  dv_r, dv_nxt_s, dv_inc_s;
  logic             conv_nxt_s, retrain_nxt_s, frozen_s, diverge_s;
  logic [WIDTH-1:0] step_nxt_s;
  logic             adapt_nxt_s;

  assign state     = cur_state_r;
  assign mag_s     = sat_abs(error);
  assign diverge_s = (mag_s > DIV_THR_V);
  assign ph_inc_s  = ph_r + PH_W'(1);
  assign dv_inc_s  = dv_r + DV_W'(1);
  assign mu_half_s = mu_r >> 1;
  assign mu_dec_s  = (mu_half_s < MU_MIN_V) ? MU_MIN_V : mu_half_s;

  // Next-state, mu, counter and flag decisions; priority start > freeze > divergence > phase count
  always_comb begin
    nxt_state_s   = cur_state_r;
    mu_nxt_s      = mu_r;
    ph_nxt_s      = ph_r;
    dv_nxt_s      = dv_r;
    conv_nxt_s    = converged;
    retrain_nxt_s = 1'b0;
    frozen_s      = 1'b0;
    if (start) begin
      nxt_state_s = ST_TRAIN;
      mu_nxt_s    = MU_INIT_V;
      ph_nxt_s    = '0;
      dv_nxt_s    = '0;
      conv_nxt_s  = 1'b0;
    end else if (freeze && (cur_state_r != ST_IDLE)) begin
      frozen_s = 1'b1;
    end else if (sample_valid) begin
      case (cur_state_r)
        ST_IDLE: begin
          conv_nxt_s = 1'b0;
        end
        ST_TRAIN: begin
          conv_nxt_s = 1'b0;
          if (ph_inc_s == TRAIN_TC) begin
            nxt_state_s = ST_DECAY;
            ph_nxt_s    = '0;
          end else begin
            ph_nxt_s = ph_inc_s;
          end
        end
        ST_DECAY, ST_TRACK: begin
          if (diverge_s && (dv_inc_s == DIV_TC)) begin
            nxt_state_s   = ST_TRAIN;
            mu_nxt_s      = MU_INIT_V;
            ph_nxt_s      = '0;
            dv_nxt_s      = '0;
            conv_nxt_s    = 1'b0;
            retrain_nxt_s = 1'b1;
          end else if (cur_state_r == ST_DECAY) begin
            dv_nxt_s   = diverge_s ? dv_inc_s : '0;
            conv_nxt_s = 1'b0;
            if (ph_inc_s == DECAY_TC) begin
              mu_nxt_s = mu_dec_s;
              ph_nxt_s = '0;
              if (mu_dec_s == MU_MIN_V) begin
                nxt_state_s = ST_TRACK;
              end else begin
                nxt_state_s = ST_DECAY;
              end
            end else begin
              ph_nxt_s = ph_inc_s;
            end
          end else begin
            dv_nxt_s   = diverge_s ? dv_inc_s : '0;
            conv_nxt_s = (mag_s <= CONV_THR_V);
          end
        end
        default: begin
          nxt_state_s = ST_IDLE;
          mu_nxt_s    = '0;
          ph_nxt_s    = '0;
          dv_nxt_s    = '0;
          conv_nxt_s  = 1'b0;
        end
      endcase
    end else begin
      frozen_s = 1'b0;
    end
    step_nxt_s  = frozen_s ? '0 : mu_nxt_s;
    adapt_nxt_s = !frozen_s && (nxt_state_s != ST_IDLE);
  end

  // State, mu, counters and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state_r <= ST_IDLE;
      mu_r        <= '0;
      ph_r        <= '0;
      dv_r        <= '0;
      step_size   <= '0;
      adapt_en    <= 1'b0;
      converged   <= 1'b0;
      retrain     <= 1'b0;
    end else begin
      cur_state_r <= nxt_state_s;
      mu_r        <= mu_nxt_s;
      ph_r        <= ph_nxt_s;
      dv_r        <= dv_nxt_s;
      step_size   <= step_nxt_s;
      adapt_en    <= adapt_nxt_s;
      converged   <= conv_nxt_s;
      retrain     <= retrain_nxt_s;
    end
  end

endmodule
